// File: rtl/axis_result_tx.sv
// AXI-stream master transmitter: buffers pipeline result samples in a DEPTH-entry FIFO and streams them out with TLAST framing.
// Optional sticky drop flag on push-while-full is enabled by defining AXIS_TX_OVERFLOW_EN.
module axis_result_tx #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  real                      in_data,
    input  logic                     in_last,
    output logic                     in_ready,
    output real                      TDATA,
    output logic                     TVALID,
    output logic                     TLAST,
    input  logic                     TREADY,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         frame_count
`ifdef AXIS_TX_OVERFLOW_EN
    ,
    output logic                     overflow
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_PARTIAL,
        ST_FULL
    } state_t;

    state_t             state_q, state_d;
    real                mem_data [DEPTH];
    logic               mem_last [DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr, rd_ptr_d;
    logic [LVL_W-1:0]   level_d;
    logic               push, pop;
    real                head_data_d;
    logic               head_last_d;

    // Occupancy state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_EMPTY;
        else     state_q <= state_d;
    end

    // Handshakes, next occupancy and the beat that will sit at the head next cycle
    always_comb begin
        push        = in_valid && in_ready;
        pop         = TVALID && TREADY;
        level_d     = level;
        rd_ptr_d    = rd_ptr;
        state_d     = state_q;
        if (push && !pop)      level_d = level + LVL_W'(1);
        else if (pop && !push) level_d = level - LVL_W'(1);
        if (pop) rd_ptr_d = rd_ptr + PTR_W'(1);
        head_data_d = mem_data[rd_ptr_d];
        head_last_d = mem_last[rd_ptr_d];
        // a push into a FIFO that is empty after this pop becomes the head immediately
        if (push && (rd_ptr_d == wr_ptr)) begin
            head_data_d = in_data;
            head_last_d = in_last;
        end
        case (state_q)
            ST_EMPTY:   if (level_d != '0) state_d = ST_PARTIAL;
            ST_PARTIAL: begin
                if (level_d == '0)                state_d = ST_EMPTY;
                else if (level_d == LVL_W'(DEPTH)) state_d = ST_FULL;
            end
            ST_FULL:    if (level_d != LVL_W'(DEPTH)) state_d = ST_PARTIAL;
            default:    state_d = ST_EMPTY;
        endcase
    end

    // Storage array; no reset needed since pointers gate every read
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= in_data;
            mem_last[wr_ptr] <= in_last;
        end
    end

    // Pointers, registered stream outputs and frame counter
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            TVALID      <= 1'b0;
            in_ready    <= 1'b1;
            TDATA       <= 0.0;
            TLAST       <= 1'b0;
            frame_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            rd_ptr   <= rd_ptr_d;
            level    <= level_d;
            TVALID   <= (state_d != ST_EMPTY);
            in_ready <= (state_d != ST_FULL);
            TDATA    <= head_data_d;
            TLAST    <= head_last_d;
            if (pop && TLAST) frame_count <= frame_count + CNT_W'(1);
        end
    end

`ifdef AXIS_TX_OVERFLOW_EN
    // Sticky flag: a sample offered while full is dropped
    always_ff @(posedge clk) begin
        if (rst)                       overflow <= 1'b0;
        else if (in_valid && !in_ready) overflow <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_axis_result_tx.sv
// Self-checking bench for axis_result_tx: directed scenarios plus random traffic against a queue-based model.
module tb_axis_result_tx;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned CNT_W = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    real        in_data = 0.0;
    logic       in_last = 1'b0;
    logic       in_ready;
    real        TDATA;
    logic       TVALID;
    logic       TLAST;
    logic       TREADY = 1'b0;
    logic [$clog2(DEPTH):0] level;
    logic [CNT_W-1:0]       frame_count;
`ifdef AXIS_TX_OVERFLOW_EN
    logic       overflow;
`endif

    axis_result_tx #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .TDATA(TDATA), .TVALID(TVALID), .TLAST(TLAST), .TREADY(TREADY),
        .level(level), .frame_count(frame_count)
`ifdef AXIS_TX_OVERFLOW_EN
        , .overflow(overflow)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        real data;
        bit  last;
    } beat_t;

    beat_t q[$];
    int    m_frames = 0;
    bit    m_ovf = 1'b0;
    int    checks = 0;
    int    failures = 0;

    task automatic check(input string tag, input real got, input real exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %f expected %f at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, advance the model by the FIFO rules, then compare after the edge
    task automatic cycle(input bit v, input real d, input bit l, input bit tr, input bit r);
        beat_t b;
        bit    rdy;
        in_valid = v; in_data = d; in_last = l; TREADY = tr; rst = r;
        if (r) begin
            q.delete();
            m_frames = 0;
            m_ovf    = 1'b0;
        end else begin
            rdy = (q.size() < DEPTH);
            if (v && !rdy) m_ovf = 1'b1;
            if (q.size() != 0 && tr) begin
                b = q.pop_front();
                if (b.last) m_frames++;
            end
            if (v && rdy) begin
                b.data = d;
                b.last = l;
                q.push_back(b);
            end
        end
        @(posedge clk);
        #1;
        check("level",       real'(level),       real'(q.size()));
        check("TVALID",      real'(TVALID),      real'(q.size() != 0));
        check("in_ready",    real'(in_ready),    real'(q.size() < DEPTH));
        check("frame_count", real'(frame_count), real'(m_frames % (1 << CNT_W)));
        if (q.size() != 0) begin
            check("TDATA", TDATA,        q[0].data);
            check("TLAST", real'(TLAST), real'(q[0].last));
        end
        if (r) begin
            check("TDATA_rst", TDATA,        0.0);
            check("TLAST_rst", real'(TLAST), 0.0);
        end
`ifdef AXIS_TX_OVERFLOW_EN
        check("overflow", real'(overflow), real'(m_ovf));
`endif
    endtask

    initial begin
        real base;
        int  start_frames;
        // Initial reset
        cycle(0, 0.0, 0, 0, 1);
        cycle(0, 0.0, 0, 0, 1);

        // Pass-through frame of three beats
        cycle(1, 1.5, 0, 1, 0);
        cycle(1, 2.5, 0, 1, 0);
        cycle(1, 3.5, 1, 1, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0.0, 0, 1, 0);
        check("frame_after_pass", real'(frame_count), 1.0);

        // Back-pressure: ten pushes into an eight-entry FIFO
        for (int i = 0; i < 10; i++) cycle(1, 10.0 + i, (i == 9), 0, 0);
        check("full_level", real'(level), real'(DEPTH));
        check("full_head",  TDATA, 10.0);
        for (int i = 0; i < 10; i++) cycle(0, 0.0, 0, 1, 0);

        // Steady push and pop at level 3 across pointer wrap
        for (int i = 0; i < 3; i++) cycle(1, 100.0 + i, 0, 0, 0);
        for (int i = 0; i < 20; i++) cycle(1, 103.0 + i, (i % 5 == 4), 1, 0);
        check("steady_level", real'(level), 3.0);
        for (int i = 0; i < 5; i++) cycle(0, 0.0, 0, 1, 0);

        // Seventeen single-beat frames wrap the 4-bit counter
        start_frames = m_frames;
        for (int i = 0; i < 17; i++) cycle(1, 200.0 + i, 1, 1, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0.0, 0, 1, 0);
        check("frame_wrap", real'(frame_count), real'((start_frames + 17) % 16));

        // Reset in the middle of a stream holding five beats
        for (int i = 0; i < 5; i++) cycle(1, 300.0 + i, 0, 0, 0);
        check("pre_rst_level", real'(level), 5.0);
        cycle(1, 400.0, 0, 1, 1);
        cycle(1, 401.0, 0, 1, 1);
        cycle(0, 0.0, 0, 1, 0);

        // Random traffic with occasional reset
        for (int i = 0; i < 3000; i++) begin
            base = real'($urandom_range(0, 4000)) / 4.0;
            cycle(($urandom_range(0, 3) != 0), base, ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 2) != 0), ($urandom_range(0, 299) == 0));
        end
        for (int i = 0; i < 12; i++) cycle(0, 0.0, 0, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/axis_result_tx.md
# axis_result_tx

AXI-stream transmitter (master end) for the cubic pipeline output. Accepts result samples from the pipeline over a simple valid/ready push port, buffers them in a DEPTH-entry FIFO, and drives them onto an AXI-stream link with full TVALID/TREADY compliance and frame delimiting via TLAST. It is the sending counterpart of the pipeline's AXI-stream slave input and sits between the last pipeline stage and the downstream consumer or testbench sink.

## Interface
- DEPTH, 8: FIFO entries; power of two, ≥2.
- CNT_W, 16: width of frame counter.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  pipeline sample valid.
- in_data  input  real  pipeline sample payload.
- in_last  input  1  sample is last of frame.
- in_ready  output  1  block can accept a sample this cycle.
- TDATA  output  real  stream payload.
- TVALID  output  1  stream data valid.
- TLAST  output  1  stream end-of-frame.
- TREADY  input  1  downstream ready.
- level  output  $clog2(DEPTH)+1  current FIFO occupancy.
- frame_count  output  CNT_W  frames fully transmitted.
- overflow  output  1  sticky drop flag (only with macro, see Configuration).

## Operation
- Push: in_valid && in_ready at a rising edge writes {in_data, in_last} at write pointer; pointer wraps DEPTH-1 → 0.
- Pop: TVALID && TREADY at a rising edge retires head entry; read pointer wraps DEPTH-1 → 0.
- in_ready = (level < DEPTH); depends only on registered state, never combinationally on TREADY or in_valid.
- TVALID = (level != 0); TDATA/TLAST = head entry; stable while TVALID && !TREADY (AXI rule: no retraction, no data change until handshake).
- Simultaneous push and pop: level unchanged; legal at any non-empty, non-full level. At level==DEPTH push is refused (in_ready=0) while pop proceeds; at level==0 no pop occurs.
- frame_count increments by 1 on each handshake with TLAST=1; wraps 2^CNT_W-1 → 0.
- No frame reassembly or length checks: TLAST passes through unchanged; zero-length frames impossible.
- State: FIFO control implicit (EMPTY: level=0; PARTIAL; FULL: level=DEPTH); transitions only on push/pop handshakes.

## Timing
- Reset values (cycle after rst sampled high): TVALID=0, TLAST=0, TDATA=0.0, in_ready=1, level=0, frame_count=0, overflow=0; pointers 0.
- rst mid-operation: FIFO flushed, in-flight beats discarded, TVALID drops on the following cycle regardless of TREADY; rst has priority over push/pop in the same cycle.
- Latency: sample pushed at edge N is presented (TVALID=1) in the cycle after edge N; pop at edge N+1 if TREADY=1.
- Throughput: one beat per cycle sustained when TREADY held high.
- level updates one cycle after the handshake edge(s).

## Configuration
- AXIS_TX_OVERFLOW_EN defined: port overflow exists; a push attempt (in_valid=1) while level==DEPTH sets overflow, sticky until rst; the sample is dropped. Frame count unaffected.
- Undefined: no overflow port or logic; in_valid while full simply waits (pipeline must honour in_ready).

## Test plan
- Reset: hold rst 2 cycles mid-stream with level=5 -> next cycle TVALID=0, level=0, frame_count=0, in_ready=1.
- Pass-through: push 1.5, 2.5, 3.5(last) with TREADY=1 -> TDATA 1.5/2.5/3.5 on consecutive cycles starting 1 cycle after first push, TLAST only on 3.5, frame_count=1.
- Back-pressure: TREADY=0 while pushing 10 samples, DEPTH=8 -> level=8, in_ready=0 after 8th, TDATA stays 1st sample; release TREADY -> all 8 delivered in order, no duplicates.
- Simultaneous push/pop at level=3 for 20 cycles -> level stays 3, output order equals input order across pointer wrap.
- Counter wrap: CNT_W=4, send 17 single-beat frames -> frame_count=1.
- With AXIS_TX_OVERFLOW_EN, push while full -> overflow=1, dropped sample never appears on TDATA; stays 1 until rst.
